spi_flash_ctl: RTL and testbench
================================

Name: spi_flash_ctl

Overview:
- Read-only SPI NOR flash bridge for the CPU memory bus.
- When the bus decoder asserts spi_ce with i_RW=1 (read), the block issues a standard READ (0x03) command and a 24-bit address, shifts in one byte, presents it on o_DATA and raises o_MemoryReady.
- Sits between the CPU address decode and the board's SPI flash pins, typically serving ROM/vector space.

Parameters:
- CLK_DIV, 1, SPI_CLK half-period in clk cycles (≥1); default gives SPI_CLK = clk/2.
- FLASH_BASE, 24'h000000, added to the zero-extended i_ADDRESS_BUS to form the flash byte address (modulo 2^24).
- CS_GAP, 2, minimum clk cycles o_SPI_CS stays high between transactions.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- spi_ce  in  1  chip enable from the address decoder.
- i_ADDRESS_BUS  in  16  CPU address.
- i_RW  in  1  1=read, 0=write.
- i_SPI_MISO  in  1  flash serial data out.
- o_SPI_CLK  out  1  SPI clock, mode 0 (idle low).
- o_SPI_MOSI  out  1  serial data to flash, MSB first.
- o_SPI_CS  out  1  flash chip select, active low.
- o_DATA  out  8  last byte read.
- o_MemoryReady  out  1  read data valid / bus cycle may complete.

Behaviour:
- Reset values: o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_DATA=8'h00, o_MemoryReady=0; state IDLE. Reset wins over every other event, including mid-transfer; an active transfer is abandoned with CS high the next cycle.
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → [DUMMY, 8 bits, FAST_READ_EN only] → DATA (8 bits) → DONE → GAP → IDLE.
- IDLE:
  - spi_ce=1, i_RW=1 and GAP satisfied → latch address = FLASH_BASE + i_ADDRESS_BUS; o_SPI_CS falls on the next edge.
  - spi_ce=1, i_RW=0 → no SPI activity; o_MemoryReady=1 on the next edge; go to DONE (writes are ignored).
- Bit timing:
  - Each bit = CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - MOSI changes only while SCK is low (at the start of the bit).
  - MISO is sampled on the clk edge where SCK rises.
- Shift order, all MSB first: opcode, then address[23:0].
- MOSI drives 0 during the DATA and DUMMY phases.
- After the 8th data bit's high phase:
  - SCK returns low, CS goes high, o_DATA is loaded and o_MemoryReady=1, all on the same edge.
  - Latency: o_MemoryReady high exactly 2 + 80·CLK_DIV cycles after the request edge (82 at default; 2 + 96·CLK_DIV with FAST_READ_EN).
- DONE:
  - o_MemoryReady and o_DATA hold while spi_ce=1.
  - spi_ce=0 → o_MemoryReady=0 next edge; go to GAP.
  - A new transaction requires spi_ce to drop first; address changes while spi_ce stays high are ignored.
- GAP: CS held high for CS_GAP cycles, then IDLE.
- Abort: spi_ce=0 during CMD/ADDR/DUMMY/DATA → CS high, SCK low next edge; o_DATA unchanged; o_MemoryReady stays 0; go to GAP.
- i_ADDRESS_BUS and i_RW are sampled only in IDLE; changes during a transfer have no effect.
- Address wrap: FLASH_BASE + 16'hFFFF wraps modulo 2^24.

Optional Feature:
- Macro: SPI_FLASH_FAST_READ_EN.
- Defined: opcode 0x0B (FAST READ) and 8 dummy SCK cycles (MOSI=0) inserted between ADDR and DATA.
- Undefined: opcode 0x03, no dummy phase.
- All other timing and handshake behaviour is identical.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants OP_READ=8'h03, OP_FAST_READ=8'h0B;
  - state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP);
  - bit-count constants (8/24/8).
- One natural sub-module, spi_bit_engine: SCK divider plus bidirectional shift register producing MOSI, sampling MISO, and flagging bit-done.
- Sequencing FSM and bus handshake stay in the top level.

Test Plan:
- Reset for 3 cycles, then read i_ADDRESS_BUS=16'hFFFD with a flash model returning 8'hA5 → MOSI stream 03 00 FF FD; o_DATA=8'hA5; o_MemoryReady high 82 cycles after the request edge; CS low for exactly 32+8 SCK periods.
- Hold spi_ce after completion, change address to 16'h1234 → no new CS activity and o_MemoryReady stays 1; drop spi_ce → ready 0 next edge; after CS_GAP, a new read of 16'h1234 returns the model byte for 24'h001234.
- Write (spi_ce=1, i_RW=0, address 16'h8000) → CS never falls; o_MemoryReady=1 one cycle later; o_DATA unchanged.
- Drop spi_ce after 20 SCK periods → CS high next edge; o_DATA keeps its prior value 8'hA5; o_MemoryReady stays 0.
- Assert reset in the ADDR phase → all outputs return to reset values on the next edge; a subsequent read of 16'h0000 with the model returning 8'h3C gives o_DATA=8'h3C.
- With SPI_FLASH_FAST_READ_EN defined, read 16'hFFFE → MOSI 0B 00 FF FE then 8 dummy zeros; o_MemoryReady at 98 cycles.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared opcodes, phase lengths and FSM states for spi_flash_ctl.
//               SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B + dummy byte).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;
    localparam int DATA_BITS  = 8;
    localparam int SHIFT_W    = CMD_BITS + ADDR_BITS;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_OPCODE = OP_FAST_READ;
    localparam bit         HAS_DUMMY   = 1'b1;
`else
    localparam logic [7:0] READ_OPCODE = OP_READ;
    localparam bit         HAS_DUMMY   = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5,
        GAP   = 3'd6
    } state_e;

    function automatic logic [4:0] phase_last_bit(input state_e st);
        case (st)
            CMD:     return 5'(CMD_BITS - 1);
            ADDR:    return 5'(ADDR_BITS - 1);
            DUMMY:   return 5'(DUMMY_BITS - 1);
            default: return 5'(DATA_BITS - 1);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_ctl_bit_engine.sv
// ============================================================================
// Module      : spi_bit_engine
// Description : Mode-0 SCK divider with MSB-first shift-out / shift-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bit_engine
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [SHIFT_W-1:0]   i_tx,
    input  logic                 i_miso,
    output logic                 o_sck,
    output logic                 o_mosi,
    output logic                 o_bit_done,
    output logic [DATA_BITS-1:0] o_rx
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic                 r_active_q, w_active_d;
    logic                 r_sck_q,    w_sck_d;
    logic [DW-1:0]        r_div_q,    w_div_d;
    logic [SHIFT_W-1:0]   r_shift_q,  w_shift_d;
    logic [DATA_BITS-1:0] r_rx_q,     w_rx_d;
    logic                 w_phase_end;

    assign w_phase_end = r_active_q && (r_div_q == DIV_LAST);
    assign o_bit_done  = w_phase_end && r_sck_q;
    assign o_sck       = r_sck_q;
    assign o_mosi      = r_shift_q[SHIFT_W-1];
    assign o_rx        = r_rx_q;

    // Zeros shift in behind the header, so MOSI is naturally 0 for dummy/data bits.
    always_comb begin
        w_active_d = r_active_q;
        w_sck_d    = r_sck_q;
        w_div_d    = r_div_q;
        w_shift_d  = r_shift_q;
        w_rx_d     = r_rx_q;
        if (i_stop) begin
            w_active_d = 1'b0;
            w_sck_d    = 1'b0;
            w_div_d    = '0;
            w_shift_d  = '0;
        end else if (i_start) begin
            w_active_d = 1'b1;
            w_sck_d    = 1'b0;
            w_div_d    = '0;
            w_shift_d  = i_tx;
        end else if (r_active_q) begin
            if (w_phase_end) begin
                w_div_d = '0;
                w_sck_d = ~r_sck_q;
                if (!r_sck_q) begin
                    w_rx_d = {r_rx_q[DATA_BITS-2:0], i_miso};
                end else begin
                    w_shift_d = {r_shift_q[SHIFT_W-2:0], 1'b0};
                end
            end else begin
                w_div_d = r_div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active_q <= 1'b0;
            r_sck_q    <= 1'b0;
            r_div_q    <= '0;
            r_shift_q  <= '0;
            r_rx_q     <= '0;
        end else begin
            r_active_q <= w_active_d;
            r_sck_q    <= w_sck_d;
            r_div_q    <= w_div_d;
            r_shift_q  <= w_shift_d;
            r_rx_q     <= w_rx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_flash_ctl.sv
// ============================================================================
// Module      : spi_flash_ctl
// Description : Read-only SPI NOR flash bridge for the CPU memory bus.
//               Build macro SPI_FLASH_FAST_READ_EN enables FAST READ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_ctl
    import spi_flash_pkg::*;
#(
    parameter int          CLK_DIV    = 1,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_ce,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic        i_SPI_MISO,
    output logic        o_SPI_CLK,
    output logic        o_SPI_MOSI,
    output logic        o_SPI_CS,
    output logic [7:0]  o_DATA,
    output logic        o_MemoryReady
);

    localparam int GW = $clog2(CS_GAP + 2);

    state_e               r_state_q,   w_state_d;
    logic [23:0]          r_addr_q,    w_addr_d;
    logic                 r_cs_q,      w_cs_d;
    logic [7:0]           r_data_q,    w_data_d;
    logic                 r_ready_q,   w_ready_d;
    logic [1:0]           r_launch_q,  w_launch_d;
    logic [4:0]           r_bit_cnt_q, w_bit_cnt_d;
    logic [GW-1:0]        r_gap_cnt_q, w_gap_cnt_d;

    logic                 w_xfer;
    logic                 w_abort;
    logic                 w_req_rd;
    logic                 w_req_wr;
    logic                 w_phase_last;
    logic                 w_gap_done;
    logic                 w_eng_stop;
    logic                 w_bit_done;
    logic [DATA_BITS-1:0] w_rx;

    assign w_xfer       = (r_state_q == CMD) || (r_state_q == ADDR) ||
                          (r_state_q == DUMMY) || (r_state_q == DATA);
    assign w_abort      = w_xfer && !spi_ce;
    assign w_req_rd     = (r_state_q == IDLE) && spi_ce && i_RW;
    assign w_req_wr     = (r_state_q == IDLE) && spi_ce && !i_RW;
    assign w_phase_last = w_bit_done && (r_bit_cnt_q == phase_last_bit(r_state_q));
    assign w_gap_done   = (int'(r_gap_cnt_q) + 1) >= CS_GAP;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (w_req_rd) begin
                    w_state_d = CMD;
                end else if (w_req_wr) begin
                    w_state_d = DONE;
                end
            end
            CMD: begin
                if (w_abort)           w_state_d = GAP;
                else if (w_phase_last) w_state_d = ADDR;
            end
            ADDR: begin
                if (w_abort)           w_state_d = GAP;
                else if (w_phase_last) w_state_d = HAS_DUMMY ? DUMMY : DATA;
            end
            DUMMY: begin
                if (w_abort)           w_state_d = GAP;
                else if (w_phase_last) w_state_d = DATA;
            end
            DATA: begin
                if (w_abort)           w_state_d = GAP;
                else if (w_phase_last) w_state_d = DONE;
            end
            DONE: begin
                if (!spi_ce) w_state_d = GAP;
            end
            GAP: begin
                if (w_gap_done) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // The two-stage launch delay places the first SCK low phase two clk after CS falls.
    always_comb begin
        w_addr_d    = r_addr_q;
        w_cs_d      = r_cs_q;
        w_data_d    = r_data_q;
        w_ready_d   = r_ready_q;
        w_launch_d  = {r_launch_q[0], 1'b0};
        w_bit_cnt_d = r_bit_cnt_q;
        w_gap_cnt_d = '0;
        w_eng_stop  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_req_rd) begin
                    w_addr_d    = FLASH_BASE + {8'h00, i_ADDRESS_BUS};
                    w_cs_d      = 1'b0;
                    w_launch_d  = 2'b01;
                    w_bit_cnt_d = '0;
                end else if (w_req_wr) begin
                    w_ready_d = 1'b1;
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                if (w_abort) begin
                    w_cs_d      = 1'b1;
                    w_eng_stop  = 1'b1;
                    w_launch_d  = 2'b00;
                    w_bit_cnt_d = '0;
                end else if (w_bit_done) begin
                    w_bit_cnt_d = w_phase_last ? 5'd0 : r_bit_cnt_q + 5'd1;
                    if ((r_state_q == DATA) && w_phase_last) begin
                        w_cs_d     = 1'b1;
                        w_data_d   = w_rx;
                        w_ready_d  = 1'b1;
                        w_eng_stop = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!spi_ce) w_ready_d = 1'b0;
            end
            GAP: begin
                w_gap_cnt_d = r_gap_cnt_q + GW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_q    <= '0;
            r_cs_q      <= 1'b1;
            r_data_q    <= 8'h00;
            r_ready_q   <= 1'b0;
            r_launch_q  <= 2'b00;
            r_bit_cnt_q <= '0;
            r_gap_cnt_q <= '0;
        end else begin
            r_addr_q    <= w_addr_d;
            r_cs_q      <= w_cs_d;
            r_data_q    <= w_data_d;
            r_ready_q   <= w_ready_d;
            r_launch_q  <= w_launch_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_gap_cnt_q <= w_gap_cnt_d;
        end
    end

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .clk        (clk),
        .reset      (reset),
        .i_start    (r_launch_q[1]),
        .i_stop     (w_eng_stop),
        .i_tx       ({READ_OPCODE, r_addr_q}),
        .i_miso     (i_SPI_MISO),
        .o_sck      (o_SPI_CLK),
        .o_mosi     (o_SPI_MOSI),
        .o_bit_done (w_bit_done),
        .o_rx       (w_rx)
    );

    assign o_SPI_CS      = r_cs_q;
    assign o_DATA        = r_data_q;
    assign o_MemoryReady = r_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_ctl.sv
// ============================================================================
// Module      : tb_spi_flash_ctl
// Description : Self-checking bench for spi_flash_ctl with a SPI flash model.
//               Honours SPI_FLASH_FAST_READ_EN for opcode/dummy expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_ctl;

    localparam int          CLK_DIV    = 1;
    localparam logic [23:0] FLASH_BASE = 24'h000000;
    localparam int          CS_GAP     = 2;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int          NDUMMY     = 8;
    localparam logic [7:0]  EXP_OP     = 8'h0B;
`else
    localparam int          NDUMMY     = 0;
    localparam logic [7:0]  EXP_OP     = 8'h03;
`endif
    localparam int          NBITS      = 40 + NDUMMY;
    localparam int          RD_LAT     = 2 + 2 * CLK_DIV * NBITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_ce = 1'b0;
    logic [15:0] addr_bus = 16'h0;
    logic        rw_sig = 1'b1;
    logic        tb_miso;
    logic        o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_MemoryReady;
    logic [7:0]  o_DATA;

    always #5 clk = ~clk;

    spi_flash_ctl #(
        .CLK_DIV    (CLK_DIV),
        .FLASH_BASE (FLASH_BASE),
        .CS_GAP     (CS_GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_ce        (spi_ce),
        .i_ADDRESS_BUS (addr_bus),
        .i_RW          (rw_sig),
        .i_SPI_MISO    (tb_miso),
        .o_SPI_CLK     (o_SPI_CLK),
        .o_SPI_MOSI    (o_SPI_MOSI),
        .o_SPI_CS      (o_SPI_CS),
        .o_DATA        (o_DATA),
        .o_MemoryReady (o_MemoryReady)
    );

    // Flash contents: two fixed bytes for the directed reads, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h00FFFD) return 8'hA5;
        if (a == 24'h000000) return 8'h3C;
        return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h69;
    endfunction

    function automatic logic [23:0] fa(input logic [15:0] a);
        return FLASH_BASE + {8'h00, a};
    endfunction

    // Flash-side model: decodes the serial header and serves the byte it names.
    int          cs_falls = 0, rises = 0, cs_low_cyc = 0, mosi_ones = 0, stray_sck = 0;
    logic [31:0] cap = '0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0;

    always @(negedge clk) begin
        if (!o_SPI_CS && prev_cs) begin
            rises = 0; cap = '0; mosi_ones = 0; cs_low_cyc = 0; cs_falls++;
        end
        if (!o_SPI_CS) begin
            cs_low_cyc++;
            if (o_SPI_CLK && !prev_sck) begin
                if (rises < 32) cap = {cap[30:0], o_SPI_MOSI};
                else if (o_SPI_MOSI) mosi_ones++;
                rises++;
            end
        end else if (o_SPI_CLK && !reset) begin
            stray_sck++;
        end
        prev_cs  = o_SPI_CS;
        prev_sck = o_SPI_CLK;
    end

    logic [7:0] miso_byte;
    int         didx;
    always_comb begin
        miso_byte = mem_byte(cap[23:0]);
        didx      = rises - 32 - NDUMMY;
        tb_miso   = 1'b0;
        if (!o_SPI_CS && didx >= 0 && didx < 8) tb_miso = miso_byte[7 - didx];
    end

    int total = 0, bad = 0;
    logic [7:0] cur_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic txn_begin(input logic [15:0] a, input logic rw, input logic [7:0] ed,
                             input int el, input int ef);
        int f0, lat;
        f0       = cs_falls;
        addr_bus = a;
        rw_sig   = rw;
        spi_ce   = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!o_MemoryReady && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, el);
        chk("data", o_DATA, ed);
        chk("cs_falls", cs_falls - f0, ef);
        chk("cs_high_at_ready", o_SPI_CS, 1);
        if (ef != 0) begin
            chk("mosi_header", cap, {EXP_OP, fa(a)});
            chk("sck_periods", rises, NBITS);
            chk("cs_low_cycles", cs_low_cyc, el);
            chk("mosi_zero_tail", mosi_ones, 0);
        end
    endtask

    task automatic txn_end();
        spi_ce = 1'b0;
        @(posedge clk); #1;
        chk("ready_drop", o_MemoryReady, 0);
        repeat (CS_GAP) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  exp_data;
        int          exp_lat;
        int          exp_falls;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] tbl_addr [8];
        logic        tbl_rw   [8];
        logic [7:0]  run;
        int          n, f0;

        tbl_addr = '{16'hFFFD, 16'h1234, 16'h8000, 16'hFFFF, 16'h0000, 16'h00FF, 16'h8001, 16'h0001};
        tbl_rw   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        run = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (tbl_rw[i]) run = mem_byte(fa(tbl_addr[i]));
            vecs[i].addr      = tbl_addr[i];
            vecs[i].rw        = tbl_rw[i];
            vecs[i].exp_data  = run;
            vecs[i].exp_lat   = tbl_rw[i] ? RD_LAT : 0;
            vecs[i].exp_falls = tbl_rw[i] ? 1 : 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", o_SPI_CS, 1);
        chk("rst_sck", o_SPI_CLK, 0);
        chk("rst_mosi", o_SPI_MOSI, 0);
        chk("rst_data", o_DATA, 8'h00);
        chk("rst_ready", o_MemoryReady, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            txn_begin(vecs[i].addr, vecs[i].rw, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_falls);
            txn_end();
        end
        cur_data = vecs[7].exp_data;

        // Completed read held by spi_ce: new address must be ignored.
        txn_begin(16'hFFFD, 1'b1, 8'hA5, RD_LAT, 1);
        f0 = cs_falls;
        addr_bus = 16'h1234;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("hold_ready", o_MemoryReady, 1);
            chk("hold_cs", o_SPI_CS, 1);
        end
        chk("hold_no_cs_fall", cs_falls - f0, 0);
        chk("hold_data", o_DATA, 8'hA5);
        txn_end();
        txn_begin(16'h1234, 1'b1, mem_byte(fa(16'h1234)), RD_LAT, 1);
        txn_end();
        txn_begin(16'hFFFD, 1'b1, 8'hA5, RD_LAT, 1);
        txn_end();
        cur_data = 8'hA5;

        // Abort after 20 SCK periods.
        f0 = cs_falls; n = 0;
        addr_bus = 16'h4321; rw_sig = 1'b1; spi_ce = 1'b1;
        while (!(cs_falls != f0 && rises >= 20) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_reached", (n < 1000) ? 1 : 0, 1);
        spi_ce = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs", o_SPI_CS, 1);
        chk("abort_sck", o_SPI_CLK, 0);
        chk("abort_ready", o_MemoryReady, 0);
        chk("abort_data", o_DATA, cur_data);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_ready_stays", o_MemoryReady, 0);
        end

        // Reset asserted during the address phase.
        f0 = cs_falls; n = 0;
        addr_bus = 16'h5555; spi_ce = 1'b1;
        while (!(cs_falls != f0 && rises >= 12) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("reset_reached", (n < 1000) ? 1 : 0, 1);
        reset = 1'b1; spi_ce = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cs", o_SPI_CS, 1);
        chk("midrst_sck", o_SPI_CLK, 0);
        chk("midrst_mosi", o_SPI_MOSI, 0);
        chk("midrst_data", o_DATA, 8'h00);
        chk("midrst_ready", o_MemoryReady, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        txn_begin(16'h0000, 1'b1, 8'h3C, RD_LAT, 1);
        txn_end();
        cur_data = 8'h3C;

        // Randomized reads/writes against the address/memory model.
        for (int r = 0; r < 24; r++) begin
            logic [15:0] a;
            logic        rw;
            logic [7:0]  ed;
            int          hold;
            a    = 16'($urandom);
            rw   = ($urandom_range(0, 3) != 0);
            ed   = rw ? mem_byte(fa(a)) : cur_data;
            txn_begin(a, rw, ed, rw ? RD_LAT : 0, rw ? 1 : 0);
            cur_data = ed;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                addr_bus = 16'($urandom);
                rw_sig   = 1'($urandom);
                @(posedge clk); #1;
            end
            chk("rand_hold_ready", o_MemoryReady, 1);
            chk("rand_hold_data", o_DATA, cur_data);
            txn_end();
        end

        chk("stray_sck", stray_sck, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
